// File: rtl/hit_judge_if.sv
// Signal bundle between the game/playfield side and the hit judge.
// hit_pulse/miss_pulse are one-cycle strobes with no back-pressure; score/combo/max_combo/perfect are valid in the strobe cycle.
interface hit_judge_if;
    logic        start;
    logic [2:0]  btn;
    logic [1:0]  active_column;
    logic [9:0]  note_y_position;
    logic        note_active;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        hit_pulse;
    logic        perfect;
    logic        miss_pulse;
    logic [2:0]  flash;
    logic [1:0]  state_dbg;

    modport master (
        output start, btn, active_column, note_y_position, note_active,
        input  score, combo, max_combo, hit_pulse, perfect, miss_pulse, flash, state_dbg
    );

    modport slave (
        input  start, btn, active_column, note_y_position, note_active,
        output score, combo, max_combo, hit_pulse, perfect, miss_pulse, flash, state_dbg
    );
endinterface

// File: rtl/hit_judge.sv
// Player-input judge: debounces fret buttons, judges each falling note once as PERFECT/GOOD/MISS,
// and keeps score, combo and per-column flash timers.
module hit_judge #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_LO          = 340,
    parameter int HIT_HI          = 400,
    parameter int PERF_LO         = 364,
    parameter int PERF_HI         = 388,
    parameter int FLASH_CYCLES    = 3000000
) (
    input logic       clk,
    input logic       rst,
    hit_judge_if.slave bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(FLASH_CYCLES + 1);
    localparam logic [9:0] HIT_LO_Y  = 10'(HIT_LO);
    localparam logic [9:0] HIT_HI_Y  = 10'(HIT_HI);
    localparam logic [9:0] PERF_LO_Y = 10'(PERF_LO);
    localparam logic [9:0] PERF_HI_Y = 10'(PERF_HI);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_JUDGED = 2'd2
    } state_t;

    state_t state, state_n;

    logic [2:0]    sync1, sync2, db, db_q, pe;
    logic [DW-1:0] db_cnt [3];
    logic [FW-1:0] flash_cnt [3];
    logic [9:0]    prev_y;
    logic [2:0]    col_oh;
    logic          in_win, in_perf, note_valid;
    logic          hit, note_miss, miss;
    logic [2:0]    add_val;
    logic [16:0]   score_sum;
    logic [7:0]    combo_inc;

    // Input path: 2-FF synchroniser then a per-bit stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else if (bus.start) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pe         = db & ~db_q;
    assign in_win     = (bus.note_y_position >= HIT_LO_Y)  && (bus.note_y_position <= HIT_HI_Y);
    assign in_perf    = (bus.note_y_position >= PERF_LO_Y) && (bus.note_y_position <= PERF_HI_Y);
    assign note_valid = bus.note_active && (bus.active_column != 2'd3);

    always_comb begin
        col_oh = 3'b000;
        case (bus.active_column)
            2'd0:    col_oh = 3'b001;
            2'd1:    col_oh = 3'b010;
            2'd2:    col_oh = 3'b100;
            default: col_oh = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            prev_y <= '0;
        end else if (bus.start) begin
            state  <= S_IDLE;
            prev_y <= '0;
        end else begin
            state  <= state_n;
            prev_y <= bus.note_y_position;
        end
    end

    // A hit outranks a note miss in the same cycle; col_oh is zero for column 3, so no hit there.
    always_comb begin
        state_n   = state;
        hit       = 1'b0;
        note_miss = 1'b0;
        case (state)
            S_IDLE: begin
                if (note_valid) state_n = S_WAIT;
            end
            S_WAIT: begin
                if ((pe != 3'b000) && (pe == col_oh) && in_win) begin
                    hit     = 1'b1;
                    state_n = S_JUDGED;
                end else if ((bus.note_y_position > HIT_HI_Y) ||
                             (!bus.note_active && (bus.note_y_position >= HIT_LO_Y))) begin
                    note_miss = 1'b1;
                    state_n   = S_JUDGED;
                end else if (!bus.note_active) begin
                    state_n = S_IDLE;
                end
            end
            S_JUDGED: begin
                if (!bus.note_active) state_n = S_IDLE;
                else if (bus.note_y_position < prev_y) state_n = S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
        miss = ((pe != 3'b000) && !hit) || note_miss;
    end

    assign bus.state_dbg = state;

    // Combo multiplier uses the combo value before this hit's increment.
    always_comb begin
        add_val   = in_perf ? 3'd2 : 3'd1;
        if (bus.combo >= 8'd10) add_val = add_val << 1;
        score_sum = {1'b0, bus.score} + {14'd0, add_val};
        combo_inc = (bus.combo == 8'hFF) ? 8'hFF : bus.combo + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.score      <= '0;
            bus.combo      <= '0;
            bus.max_combo  <= '0;
            bus.hit_pulse  <= 1'b0;
            bus.perfect    <= 1'b0;
            bus.miss_pulse <= 1'b0;
        end else if (bus.start) begin
            bus.score      <= '0;
            bus.combo      <= '0;
            bus.max_combo  <= '0;
            bus.hit_pulse  <= 1'b0;
            bus.perfect    <= 1'b0;
            bus.miss_pulse <= 1'b0;
        end else begin
            bus.hit_pulse  <= hit;
            bus.perfect    <= hit && in_perf;
            bus.miss_pulse <= miss && !hit;
            if (hit) begin
                bus.score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                bus.combo <= combo_inc;
                if (combo_inc > bus.max_combo) bus.max_combo <= combo_inc;
            end else if (miss) begin
                bus.combo <= '0;
            end
        end
    end

    // Flash timers: load on a hit in that column, count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) flash_cnt[i] <= '0;
        end else if (bus.start) begin
            for (int i = 0; i < 3; i++) flash_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (hit && col_oh[i]) flash_cnt[i] <= FW'(FLASH_CYCLES);
                else if (flash_cnt[i] != '0) flash_cnt[i] <= flash_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        bus.flash = 3'b000;
        for (int i = 0; i < 3; i++) bus.flash[i] = (flash_cnt[i] != '0);
    end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: judgement events are predicted into a queue when presses are driven
// and compared as the DUT strobes hit_pulse/miss_pulse.
module tb_hit_judge;

    localparam int DEB = 4;
    localparam int FL  = 8;

    logic clk = 1'b0;
    logic rst;
    hit_judge_if bus ();

    hit_judge #(.DEBOUNCE_CYCLES(DEB), .FLASH_CYCLES(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock/reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_score, m_combo, m_max;
    logic [34:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] pack(input logic [1:0] kind, input logic perf, input logic [15:0] sc,
                                         input logic [7:0] cb, input logic [7:0] mx);
        return {kind, perf, sc, cb, mx};
    endfunction

    // Scoreboard side: compare each strobe against the oldest prediction.
    always @(negedge clk) begin
        if (rst === 1'b0 && (bus.hit_pulse || bus.miss_pulse)) begin
            logic [34:0] obs;
            obs = pack(bus.hit_pulse ? 2'd1 : 2'd2, bus.hit_pulse & bus.perfect,
                       bus.score, bus.combo, bus.max_combo);
            check("one_pulse", {63'd0, bus.hit_pulse & bus.miss_pulse}, 64'd0);
            if (exp_q.size() == 0) check("unexpected_evt", {29'd0, obs}, 64'd0);
            else check("evt", {29'd0, obs}, {29'd0, exp_q.pop_front()});
        end
    end

    task automatic exp_hit(input bit perf);
        int add;
        add = perf ? 2 : 1;
        if (m_combo >= 10) add = add * 2;
        m_score = (m_score + add > 65535) ? 65535 : m_score + add;
        m_combo = (m_combo == 255) ? 255 : m_combo + 1;
        if (m_combo > m_max) m_max = m_combo;
        exp_q.push_back(pack(2'd1, perf, 16'(m_score), 8'(m_combo), 8'(m_max)));
    endtask

    task automatic exp_miss();
        m_combo = 0;
        exp_q.push_back(pack(2'd2, 1'b0, 16'(m_score), 8'(m_combo), 8'(m_max)));
    endtask

    task automatic model_clear();
        m_score = 0;
        m_combo = 0;
        m_max   = 0;
    endtask

    // Drivers
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            step(1);
            k++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic press(input int b, input int fcol, output int fh);
        fh = 0;
        bus.btn[b] = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) bus.btn[b] = 1'b0;
            step(1);
            if (bus.flash[fcol]) fh++;
        end
    endtask

    task automatic note_on(input logic [1:0] col, input logic [9:0] y);
        bus.active_column   = col;
        bus.note_y_position = y;
        bus.note_active     = 1'b1;
        step(2);
    endtask

    task automatic note_off();
        bus.note_active = 1'b0;
        step(2);
    endtask

    task automatic hit_note(input int col, input logic [9:0] y, input bit perf, input string tag);
        int fh;
        note_on(2'(col), y);
        exp_hit(perf);
        press(col, col, fh);
        check({tag, "_flash_len"}, 64'(fh), 64'(FL));
        wait_drain({tag, "_drain"});
        note_off();
    endtask

    initial begin
        int fh;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.btn = 3'b000;
        bus.active_column = 2'd3;
        bus.note_y_position = '0;
        bus.note_active = 1'b0;
        model_clear();
        step(3);
        check("rst_score", 64'(bus.score), 64'd0);
        check("rst_combo", 64'(bus.combo), 64'd0);
        check("rst_flash", 64'(bus.flash), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        rst = 1'b0;
        step(2);

        // Perfect hit on column 1
        hit_note(1, 10'd370, 1'b1, "t2");
        check("t2_score", 64'(bus.score), 64'd2);
        check("t2_combo", 64'(bus.combo), 64'd1);

        // Build combo to 10, then a GOOD hit with the doubled add
        for (int i = 0; i < 9; i++) hit_note(i % 3, 10'd370, 1'b1, "build");
        check("build_combo", 64'(bus.combo), 64'd10);
        hit_note(0, 10'd345, 1'b0, "t3");
        check("t3_score", 64'(bus.score), 64'd22);
        check("t3_combo", 64'(bus.combo), 64'd11);
        check("t3_max", 64'(bus.max_combo), 64'd11);

        // Asynchronous reset mid-game
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_score", 64'(bus.score), 64'd0);
        check("t1_combo", 64'(bus.combo), 64'd0);
        check("t1_max", 64'(bus.max_combo), 64'd0);
        check("t1_state", 64'(bus.state_dbg), 64'd0);
        step(2);
        rst = 1'b0;
        model_clear();
        step(10);

        // Miss by falling past the window, then a late press is a bad press
        hit_note(2, 10'd370, 1'b1, "t4pre");
        note_on(2'd2, 10'd399);
        exp_miss();
        bus.note_y_position = 10'd401;
        step(1);
        check("t4_miss_timing", 64'(bus.miss_pulse), 64'd1);
        check("t4_combo", 64'(bus.combo), 64'd0);
        wait_drain("t4_drain");
        exp_miss();
        press(2, 2, fh);
        check("t4_no_flash", 64'(fh), 64'd0);
        wait_drain("t4_bad_drain");
        note_off();

        // Bouncing button makes no press; wrong column is a bad press; note stays hittable
        hit_note(0, 10'd370, 1'b1, "t5pre");
        for (int i = 0; i < 20; i++) begin
            bus.btn[0] = (i % 3 == 0);
            step(1);
        end
        bus.btn[0] = 1'b0;
        step(8);
        check("t5_bounce_combo", 64'(bus.combo), 64'd1);
        note_on(2'd1, 10'd370);
        exp_miss();
        press(2, 1, fh);
        wait_drain("t5_bad_drain");
        check("t5_bad_combo", 64'(bus.combo), 64'd0);
        exp_hit(1'b1);
        press(1, 1, fh);
        check("t5_flash_len", 64'(fh), 64'(FL));
        wait_drain("t5_hit_drain");
        note_off();

        // Score saturation, then synchronous start clear
        note_on(2'd0, 10'd370);
        force dut.bus.score = 16'hFFFE;
        step(1);
        release dut.bus.score;
        m_score = 65534;
        exp_hit(1'b1);
        press(0, 0, fh);
        wait_drain("t6_drain");
        check("t6_sat", 64'(bus.score), 64'hFFFF);
        note_off();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        model_clear();
        check("t6_start_score", 64'(bus.score), 64'd0);
        check("t6_start_combo", 64'(bus.combo), 64'd0);
        check("t6_start_max", 64'(bus.max_combo), 64'd0);

        // Final report
        step(5);
        check("q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
